backing_memory_responder: RTL and testbench
===========================================

// Module: backing_memory_responder
// PURPOSE
//  Main-memory responder on the downstream side of the cache's miss/write path.
//  Accepts one request at a time over a valid/ready handshake.
//  Reads: after a fixed latency, returns a whole cache line as BLOCK_WORDS consecutive beats.
//  Writes: commits a single word after the latency, then returns a one-beat acknowledge.
//  Sits between the data cache controller and the behavioural/FPGA main store.
// PARAMETERS
//  DEPTH_WORDS  256  storage depth in 32-bit words, power of two
//  BLOCK_WORDS  4    words per cache line (burst length), power of two, <= DEPTH_WORDS
//  LATENCY      4    cycles from request accept to first response beat, >= 1
// PORTS
//  clk        in   1   single clock, all state changes on rising edge
//  rst        in   1   reset, asynchronous, active-low
//  req_valid  in   1   request present
//  req_ready  out  1   responder idle, request accepted when req_valid & req_ready
//  req_write  in   1   1 = word write, 0 = line read
//  req_addr   in   32  byte address; bits [1:0] ignored
//  req_wdata  in   32  write data, sampled at accept
//  resp_valid out  1   response beat valid; no backpressure, consumer must take every beat
//  resp_data  out  32  read beat data; 0 on write acknowledge
//  resp_last  out  1   final beat of a response; always 1 on write acknowledge
// BEHAVIOUR
//  Reset (rst=0):
//   - Forces req_ready=0, resp_valid=0, resp_data=0, resp_last=0, FSM=IDLE, counters=0,
//     asynchronously.
//   - Storage array is not cleared; its contents survive reset.
//  Addressing:
//   - Word index = req_addr[log2(DEPTH_WORDS)+1:2]; upper bits ignored, so addresses wrap
//     modulo DEPTH_WORDS.
//   - Read base = word index with its low log2(BLOCK_WORDS) bits cleared.
//   - Read beats return base, base+1, ... base+BLOCK_WORDS-1, in order.
//  FSM IDLE -> WAIT -> (READ_BURST | WRITE_ACK) -> IDLE:
//   - IDLE: req_ready=1. Accept at edge k latches write/addr/wdata and loads
//     lat_cnt=LATENCY-1; req_ready=0 from k onward.
//   - WAIT: lat_cnt decrements each edge. The edge where lat_cnt==0 is edge k+LATENCY-1;
//     it moves to READ_BURST (read) or WRITE_ACK (write).
//   - WRITE commit: the memory write happens on that same edge k+LATENCY-1.
//   - WRITE_ACK: resp_valid=1, resp_last=1, resp_data=0 for exactly one cycle
//     (after edge k+LATENCY-1), then IDLE.
//   - READ_BURST: first beat is valid in the cycle after edge k+LATENCY-1.
//     BLOCK_WORDS beats on consecutive cycles, no gaps; resp_last=1 only on the final beat.
//     Then IDLE.
//   - Ready timing: req_ready returns to 1 in the cycle after the last beat/ack.
//     Minimum request spacing is LATENCY+BLOCK_WORDS (read) or LATENCY+1 (write) cycles.
//  Boundary rules:
//   - req_valid while req_ready=0 is ignored; the requester must hold valid until accepted.
//   - Burst data are read from storage as stored at first-beat time.
//   - No read/write overlap is possible: one outstanding request only.
//   - Reset mid-WAIT before the commit edge: the write is discarded.
//   - Reset mid-burst: resp_valid drops immediately and the remaining beats are lost.
//   - Outputs are registered; resp_data/resp_last are 0 whenever resp_valid=0.
// TESTING (defaults: DEPTH_WORDS=256, BLOCK_WORDS=4, LATENCY=4, clk period 10ns)
//  1. Reset: rst=0 for 25ns
//     -> req_ready=0, resp_valid=0 throughout.
//     Release -> req_ready=1 after the first rising edge.
//  2. Write: req_write=1, addr=7, wdata=10, accepted at edge k
//     -> single ack beat in the cycle after edge k+3, resp_last=1, resp_data=0;
//        req_ready=1 one cycle later.
//  3. Read: addr=0x4 after test 2
//     -> 4 beats [mem0, 10, mem2, mem3], resp_last only on beat 4, no gaps.
//     addr=0xC -> same base 0, same beats.
//  4. Busy: pulse a second req_valid during the WAIT/burst of a read
//     -> not accepted and no extra beats. Held valid -> accepted exactly when
//        req_ready returns.
//  5. Wrap: write addr=0x400, data=0xA5
//     -> lands in word 0; a read of addr=0x0 returns 0xA5 on beat 1.
//  6. Reset mid-burst, asserted during beat 2
//     -> resp_valid=0 immediately, req_ready=1 after release; a re-read returns the
//        same line contents.
//     Reset during WAIT of a write to word 9 (0x55) -> word 9 unchanged on read-back.

Source files
------------

// File: rtl/backing_memory_responder_if.sv
// Request/response bus between the cache miss/write path and the main store.
`timescale 1ns/1ps
interface backing_memory_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        resp_last;

  modport master (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_data, resp_last
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready, resp_valid, resp_data, resp_last
  );
endinterface

// File: rtl/backing_memory_responder.sv
// Main-memory responder: one request at a time, fixed latency, returns a
// whole cache line for reads and a single-beat acknowledge for word writes.
`timescale 1ns/1ps
module backing_memory_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int BLOCK_WORDS = 4,
  parameter int LATENCY     = 4
) (
  input logic                       clk,
  input logic                       rst,
  backing_memory_responder_if.slave bus
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = $clog2(BLOCK_WORDS) + 1;
  localparam int LW = $clog2(LATENCY + 1);
  localparam logic [AW-1:0] LINE_MASK  = AW'(BLOCK_WORDS - 1);
  localparam logic [CW-1:0] LAST_BEAT  = CW'(BLOCK_WORDS - 1);
  localparam logic [CW-1:0] BURST_DONE = CW'(BLOCK_WORDS);
  localparam logic [LW-1:0] LAT_LOAD   = LW'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WAIT, READ_BURST, WRITE_ACK} state_t;

  state_t        state, state_nxt;
  logic [LW-1:0] lat_cnt, lat_nxt;
  logic [CW-1:0] beat_cnt, beat_nxt;
  logic          ready_q, ready_nxt;
  logic          valid_q, valid_nxt;
  logic          last_q, last_nxt;
  logic [31:0]   data_q, data_nxt;

  logic          hold_write;
  logic [AW-1:0] hold_idx;
  logic [31:0]   hold_wdata;

  logic [31:0]   mem [DEPTH_WORDS];

  logic          accept, go_resp, commit;
  logic          cur_write;
  logic [AW-1:0] cur_idx, line_base;
  logic [31:0]   cur_wdata;
  logic          unused_addr_bits;

  // ready_q is only ever high in IDLE, so accept implies IDLE.
  assign accept    = bus.req_valid & ready_q;
  // In IDLE the request is taken straight off the bus (only matters for LATENCY=1).
  assign cur_write = (state == IDLE) ? bus.req_write : hold_write;
  assign cur_idx   = (state == IDLE) ? bus.req_addr[AW+1:2] : hold_idx;
  assign cur_wdata = (state == IDLE) ? bus.req_wdata : hold_wdata;
  assign line_base = cur_idx & ~LINE_MASK;
  assign unused_addr_bits = ^{bus.req_addr[31:AW+2], bus.req_addr[1:0]};

  // Next-state and next-output decode; outputs are registered from these.
  always_comb begin
    state_nxt = state;
    lat_nxt   = lat_cnt;
    beat_nxt  = beat_cnt;
    ready_nxt = 1'b0;
    valid_nxt = 1'b0;
    last_nxt  = 1'b0;
    data_nxt  = '0;
    commit    = 1'b0;
    go_resp   = 1'b0;
    case (state)
      IDLE: begin
        ready_nxt = 1'b1;
        if (accept) begin
          ready_nxt = 1'b0;
          if (LATENCY == 1) begin
            go_resp = 1'b1;
          end else begin
            state_nxt = WAIT;
            lat_nxt   = LAT_LOAD;
          end
        end
      end
      WAIT: begin
        lat_nxt = lat_cnt - LW'(1);
        // Counter reaching zero on this edge: first beat/ack leaves now.
        if (lat_cnt == LW'(1)) go_resp = 1'b1;
      end
      READ_BURST: begin
        if (beat_cnt == BURST_DONE) begin
          state_nxt = IDLE;
          ready_nxt = 1'b1;
          beat_nxt  = '0;
        end else begin
          valid_nxt = 1'b1;
          data_nxt  = mem[line_base + AW'(beat_cnt)];
          last_nxt  = (beat_cnt == LAST_BEAT);
          beat_nxt  = beat_cnt + CW'(1);
        end
      end
      WRITE_ACK: begin
        state_nxt = IDLE;
        ready_nxt = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
    if (go_resp) begin
      valid_nxt = 1'b1;
      if (cur_write) begin
        commit    = 1'b1;
        state_nxt = WRITE_ACK;
        last_nxt  = 1'b1;
      end else begin
        state_nxt = READ_BURST;
        data_nxt  = mem[line_base];
        last_nxt  = (BLOCK_WORDS == 1);
        beat_nxt  = CW'(1);
      end
    end
  end

  // Control and output registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      lat_cnt  <= '0;
      beat_cnt <= '0;
      ready_q  <= 1'b0;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
      data_q   <= '0;
    end else begin
      state    <= state_nxt;
      lat_cnt  <= lat_nxt;
      beat_cnt <= beat_nxt;
      ready_q  <= ready_nxt;
      valid_q  <= valid_nxt;
      last_q   <= last_nxt;
      data_q   <= data_nxt;
    end
  end

  // Capture the accepted request for use during WAIT.
  always_ff @(posedge clk) begin
    if (accept) begin
      hold_write <= bus.req_write;
      hold_idx   <= bus.req_addr[AW+1:2];
      hold_wdata <= bus.req_wdata;
    end
  end

  // Storage array; deliberately not reset so contents survive rst.
  always_ff @(posedge clk) begin
    if (commit) mem[cur_idx] <= cur_wdata;
  end

  assign bus.req_ready  = ready_q;
  assign bus.resp_valid = valid_q;
  assign bus.resp_data  = data_q;
  assign bus.resp_last  = last_q;
endmodule

// File: tb/tb_backing_memory_responder.sv
// Bench for backing_memory_responder: random requests against an array
// reference model, with a queue scoreboard drained by a response monitor.
`timescale 1ns/1ps
module tb_backing_memory_responder;
  localparam int DEPTH = 256;
  localparam int BW    = 4;
  localparam int LAT   = 4;

  typedef struct {
    logic [31:0] data;
    logic        last;
    int          cyc;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   passes = 0;
  int   last_n = -1;
  bit   last_w = 1'b0;

  logic [31:0] ref_mem [DEPTH];
  beat_t       exp_q [$];
  beat_t       mb;

  backing_memory_responder_if bus ();

  backing_memory_responder #(
    .DEPTH_WORDS(DEPTH),
    .BLOCK_WORDS(BW),
    .LATENCY(LAT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input logic ok, input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (ok === 1'b1) passes++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor: every beat must match the head of the expected queue, including its cycle.
  always @(negedge clk) begin
    if (bus.resp_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk(1'b0, "unexpected_beat", bus.resp_data, 32'h0);
      end else begin
        mb = exp_q.pop_front();
        chk(bus.resp_data === mb.data, "beat_data", bus.resp_data, mb.data);
        chk(bus.resp_last === mb.last, "beat_last", 32'(bus.resp_last), 32'(mb.last));
        chk(cyc == mb.cyc, "beat_cycle", 32'(cyc), 32'(mb.cyc));
      end
    end else begin
      chk({bus.resp_last, bus.resp_data} === 33'h0, "idle_outputs_zero", bus.resp_data, 32'h0);
    end
  end

  // Issue one request; holds valid until accepted. track=0 means the request
  // is expected to be killed by reset, so the model is left untouched.
  task automatic issue(input bit w, input logic [31:0] a, input logic [31:0] d,
                       input bit b2b, input bit track, output int n);
    int guard;
    int idx;
    int base;
    beat_t e;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_write = w;
    bus.req_addr  = a;
    bus.req_wdata = d;
    guard = 0;
    while (bus.req_ready !== 1'b1 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    n = cyc;
    if (guard >= 200) begin
      chk(1'b0, "accept_timeout", 32'(bus.req_ready), 32'h1);
      bus.req_valid = 1'b0;
      return;
    end
    if (b2b && last_n >= 0)
      chk(n == last_n + LAT + (last_w ? 1 : BW), "ready_return_cycle", 32'(n),
          32'(last_n + LAT + (last_w ? 1 : BW)));
    last_n = n;
    last_w = w;
    if (track) begin
      idx = int'(a / 4) % DEPTH;
      if (w) begin
        ref_mem[idx] = d;
        e.data = 32'h0; e.last = 1'b1; e.cyc = n + LAT;
        exp_q.push_back(e);
      end else begin
        base = idx - (idx % BW);
        for (int i = 0; i < BW; i++) begin
          e.data = ref_mem[(base + i) % DEPTH];
          e.last = (i == BW - 1);
          e.cyc  = n + LAT + i;
          exp_q.push_back(e);
        end
      end
    end
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
  endtask

  initial begin
    int n;
    int g;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;

    // Reset held for three cycles
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk(bus.req_ready === 1'b0, "reset_ready_low", 32'(bus.req_ready), 32'h0);
      chk(bus.resp_valid === 1'b0, "reset_valid_low", 32'(bus.resp_valid), 32'h0);
    end
    rst = 1'b1;
    @(negedge clk);
    chk(bus.req_ready === 1'b1, "ready_after_release", 32'(bus.req_ready), 32'h1);

    // Fill storage with known random data
    for (int i = 0; i < DEPTH; i++) issue(1'b1, 32'(i * 4), $urandom, 1'b1, 1'b1, n);

    // Write byte address 7 (word 1), then line reads at 0x4 and 0xC
    issue(1'b1, 32'h7, 32'd10, 1'b1, 1'b1, n);
    issue(1'b0, 32'h4, 32'h0, 1'b1, 1'b1, n);
    issue(1'b0, 32'hC, 32'h0, 1'b1, 1'b1, n);

    // Busy: stray pulse during a read must be ignored; held request accepted on ready return
    issue(1'b0, 32'h10, 32'h0, 1'b1, 1'b1, n);
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_addr = 32'h30; bus.req_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    bus.req_valid = 1'b0;
    issue(1'b0, 32'h50, 32'h0, 1'b1, 1'b1, n);
    issue(1'b0, 32'h30, 32'h0, 1'b1, 1'b1, n);

    // Address wrap: 0x400 lands in word 0
    issue(1'b1, 32'h400, 32'hA5, 1'b1, 1'b1, n);
    issue(1'b0, 32'h0, 32'h0, 1'b1, 1'b1, n);

    // Reset during beat 2 of a burst
    issue(1'b0, 32'h0, 32'h0, 1'b1, 1'b1, n);
    while (cyc < n + LAT + 1) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk(bus.resp_valid === 1'b0, "reset_kills_burst", 32'(bus.resp_valid), 32'h0);
    chk(bus.req_ready === 1'b0, "reset_ready_mid_burst", 32'(bus.req_ready), 32'h0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk(bus.req_ready === 1'b1, "ready_after_burst_reset", 32'(bus.req_ready), 32'h1);
    issue(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, n);

    // Reset during WAIT of a write to word 9: write must be discarded
    issue(1'b1, 32'h24, 32'h55, 1'b1, 1'b0, n);
    @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    issue(1'b0, 32'h24, 32'h0, 1'b0, 1'b1, n);

    // Random traffic
    for (int i = 0; i < 80; i++)
      issue(1'(($urandom % 2)), $urandom, $urandom, 1'b1, 1'b1, n);

    g = 0;
    while (exp_q.size() != 0 && g < 100) begin
      @(negedge clk);
      g++;
    end
    chk(exp_q.size() == 0, "scoreboard_drained", 32'(exp_q.size()), 32'h0);
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end
endmodule
